// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment display peripheral: register map,
// CTRL field positions, CTRL reset value and the hex-to-segment table.
package sevenseg_pkg;

    localparam logic [1:0] SS_ADDR_DATA   = 2'd0;
    localparam logic [1:0] SS_ADDR_CTRL   = 2'd1;
    localparam logic [1:0] SS_ADDR_STATUS = 2'd2;

    localparam int CTRL_DP_LSB     = 0;
    localparam int CTRL_BLANK_LSB  = 8;
    localparam int CTRL_BRIGHT_LSB = 16;
    localparam int CTRL_LZS_BIT    = 20;

    localparam logic [31:0] CTRL_RESET = 32'h000F_0000;

    // Segment patterns g..a (bit 0 = a), active-high.
    localparam logic [6:0] SS_HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational 4-bit hex value to active-high a..g segment lookup.
module sevenseg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SS_HEX_SEG[nibble_i];

endmodule

// File: rtl/wb_sevenseg_mux.sv
// Pipelined Wishbone slave driving a time-multiplexed seven-segment bank.
// Optional leading-zero suppression is built when SEVENSEG_LZS_EN is defined.
module wb_sevenseg_mux
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SLOT_DIV   = 3125,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_we,
    input  logic [29:0]           i_wb_addr,
    input  logic [31:0]           i_wb_data,
    input  logic [3:0]            i_wb_sel,
    output logic                  o_wb_ack,
    output logic                  o_wb_stall,
    output logic [31:0]           o_wb_data,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [NUM_DIGITS-1:0] o_an
);

    localparam int              PRE_W     = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(SLOT_DIV - 1);
    localparam logic [2:0]      IDX_MAX   = 3'(NUM_DIGITS - 1);
    localparam logic [31:0]     DATA_MASK = 32'hFFFF_FFFF >> (32 - 4 * NUM_DIGITS);
    localparam logic [7:0]      DIG_MASK  = 8'hFF >> (8 - NUM_DIGITS);
`ifdef SEVENSEG_LZS_EN
    localparam logic            LZS_IMPL  = 1'b1;
`else
    localparam logic            LZS_IMPL  = 1'b0;
`endif
    localparam logic [31:0]     CTRL_MASK = {11'd0, LZS_IMPL, 4'hF, DIG_MASK, DIG_MASK};

    logic [31:0]           data_q, data_d, ctrl_q, ctrl_d, rdata_q, rdata_d;
    logic [31:0]           rd_mux, wmask, status_w;
    logic                  ack_q, ack_d, accept, wr_data, wr_ctrl;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [3:0]            phase_q, phase_d;
    logic [2:0]            idx_q, idx_d;
    logic                  pre_wrap;
    logic [6:0]            seg_q, seg_d, dec_seg;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [3:0]            nibble, bright;
    logic [7:0]            blank, dp_mask, lzs_sup;
    logic                  lit;
    logic                  unused_addr;

    assign unused_addr = ^i_wb_addr[29:2];

    // Bus handshake: stall is never raised, so every cycle with cyc&&stb is a
    // transfer; ack follows one cycle later with read data and is masked by cyc.
    always_comb begin
        accept   = i_wb_cyc && i_wb_stb;
        status_w = {24'd0, phase_q, 1'b0, idx_q};
        case (i_wb_addr[1:0])
            SS_ADDR_DATA:   rd_mux = data_q;
            SS_ADDR_CTRL:   rd_mux = ctrl_q;
            SS_ADDR_STATUS: rd_mux = status_w;
            default:        rd_mux = 32'd0;
        endcase
        wmask   = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
        wr_data = accept && i_wb_we && (i_wb_addr[1:0] == SS_ADDR_DATA);
        wr_ctrl = accept && i_wb_we && (i_wb_addr[1:0] == SS_ADDR_CTRL);
        data_d  = wr_data ? (((data_q & ~wmask) | (i_wb_data & wmask)) & DATA_MASK) : data_q;
        ctrl_d  = wr_ctrl ? (((ctrl_q & ~wmask) | (i_wb_data & wmask)) & CTRL_MASK) : ctrl_q;
        ack_d   = accept;
        rdata_d = accept ? rd_mux : rdata_q;
    end

    always_comb begin
        pre_wrap = (pre_q == PRE_MAX);
        pre_d    = pre_wrap ? '0 : pre_q + PRE_W'(1);
        phase_d  = pre_wrap ? phase_q + 4'd1 : phase_q;
        idx_d    = idx_q;
        if (pre_wrap && (phase_q == 4'hF)) begin
            idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
        end
    end

`ifdef SEVENSEG_LZS_EN
    // A digit is suppressed when it and every digit above it hold zero.
    logic zero_above;
    always_comb begin
        lzs_sup    = '0;
        zero_above = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            zero_above = zero_above && (data_q[4*i +: 4] == 4'd0);
            lzs_sup[i] = zero_above && ctrl_q[CTRL_LZS_BIT];
        end
    end
`else
    assign lzs_sup = '0;
`endif

    always_comb begin
        nibble  = data_q[{idx_q, 2'b00} +: 4];
        bright  = ctrl_q[CTRL_BRIGHT_LSB +: 4];
        blank   = ctrl_q[CTRL_BLANK_LSB +: 8];
        dp_mask = ctrl_q[CTRL_DP_LSB +: 8];
        lit     = (phase_q <= bright) && !blank[idx_q] && !lzs_sup[idx_q];
        seg_d   = lit ? dec_seg : 7'd0;
        dp_d    = lit && dp_mask[idx_q];
        an_d    = '0;
        if (lit) begin
            an_d[idx_q] = 1'b1;
        end
    end

    sevenseg_hex_decode u_dec (
        .nibble_i (nibble),
        .seg_o    (dec_seg)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_q  <= 32'd0;
            ctrl_q  <= CTRL_RESET & CTRL_MASK;
            rdata_q <= 32'd0;
            ack_q   <= 1'b0;
            pre_q   <= '0;
            phase_q <= 4'd0;
            idx_q   <= 3'd0;
            seg_q   <= 7'd0;
            dp_q    <= 1'b0;
            an_q    <= '0;
        end else begin
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            pre_q   <= pre_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign o_wb_ack   = ack_q && i_wb_cyc;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = rdata_q;
    assign o_seg      = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign o_dp       = (ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
    assign o_an       = (ACTIVE_LOW != 0) ? ~an_q  : an_q;

endmodule

// File: tb/tb_wb_sevenseg_mux.sv
// Directed bench for wb_sevenseg_mux with SLOT_DIV = 1 (one phase per clock).
// Expectations follow SEVENSEG_LZS_EN when the bench is built with it.
module tb_wb_sevenseg_mux;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
    logic [29:0] i_wb_addr = '0;
    logic [31:0] i_wb_data = '0;
    logic [3:0]  i_wb_sel = '0;
    logic        o_wb_ack, o_wb_stall, o_dp;
    logic [31:0] o_wb_data;
    logic [6:0]  o_seg;
    logic [7:0]  o_an;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    int          an_cnt[8];
    int          multi_cnt;

    wb_sevenseg_mux #(.NUM_DIGITS(8), .SLOT_DIV(1), .ACTIVE_LOW(1)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .i_wb_sel   (i_wb_sel),
        .o_wb_ack   (o_wb_ack),
        .o_wb_stall (o_wb_stall),
        .o_wb_data  (o_wb_data),
        .o_seg      (o_seg),
        .o_dp       (o_dp),
        .o_an       (o_an)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] addr, input logic [31:0] d,
                         input logic [3:0] sel);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_addr = {28'd0, addr};
        i_wb_data = d;
        i_wb_sel  = sel;
    endtask

    task automatic xfer(input logic we, input logic [1:0] addr, input logic [31:0] d,
                        input logic [3:0] sel, output logic [31:0] rd, output logic ack);
        @(negedge i_clk);
        drive(we, addr, d, sel);
        @(negedge i_clk);
        ack      = o_wb_ack;
        rd       = o_wb_data;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        i_wb_cyc = 1'b0;
    endtask

    task automatic count_an();
        logic [7:0] act;
        for (int i = 0; i < 8; i++) an_cnt[i] = 0;
        multi_cnt = 0;
        repeat (128) begin
            @(negedge i_clk);
            act = ~o_an;
            if ($countones(act) > 1) multi_cnt++;
            for (int i = 0; i < 8; i++) if (act[i]) an_cnt[i]++;
        end
    endtask

    task automatic wait_an(input logic [7:0] want, input string tag);
        int n = 0;
        while ((~o_an !== want) && (n < 300)) begin
            @(negedge i_clk);
            n++;
        end
        check(tag, {24'd0, ~o_an}, {24'd0, want});
    endtask

    initial begin
        logic [31:0] rd;
        logic        ack;
        int          acks;
        int          stall_bad;
        int          slot_len;
        logic        v_we[4];
        logic [1:0]  v_addr[4];
        logic [31:0] v_dat[4];

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_an", {24'd0, o_an}, 32'h0000_00FF);
        check("rst_seg", {25'd0, o_seg}, 32'h0000_007F);
        check("rst_dp", {31'd0, o_dp}, 32'd1);
        check("rst_ack", {31'd0, o_wb_ack}, 32'd0);
        check("rst_rdata", o_wb_data, 32'd0);
        i_reset = 1'b0;

        xfer(1'b0, 2'd1, 32'd0, 4'hF, rd, ack);
        check("ctrl_rd_ack", {31'd0, ack}, 32'd1);
        check("ctrl_rd_data", rd, 32'h000F_0000);

        // Byte-enabled write; ack data is the pre-write value
        xfer(1'b1, 2'd0, 32'h8765_4321, 4'b0011, rd, ack);
        check("data_wr_ack", {31'd0, ack}, 32'd1);
        check("data_wr_old", rd, 32'd0);
        xfer(1'b0, 2'd0, 32'd0, 4'hF, rd, ack);
        check("data_rd_sel", rd, 32'h0000_4321);

        // Scan rotation: each digit holds for 16 clocks
        wait_an(8'h01, "wait_dig0");
        check("dig0_seg", {25'd0, o_seg}, {25'd0, ~7'h06});
        check("dig0_dp", {31'd0, o_dp}, 32'd1);
        wait_an(8'h02, "wait_dig1");
        check("dig1_seg", {25'd0, o_seg}, {25'd0, ~7'h5B});
        slot_len = 1;
        for (int n = 0; n < 40; n++) begin
            @(negedge i_clk);
            if (~o_an == 8'h02) slot_len++;
            else break;
        end
        check("slot_len", slot_len, 32'd16);
        check("dig2_an", {24'd0, ~o_an}, 32'h0000_0004);
        check("dig2_seg", {25'd0, o_seg}, {25'd0, ~7'h4F});

        // Back-to-back strobes: write, read, write, read
        v_we   = '{1'b1, 1'b0, 1'b1, 1'b0};
        v_addr = '{2'd0, 2'd0, 2'd1, 2'd1};
        v_dat  = '{32'h1234_5678, 32'd0, 32'h0003_0200, 32'd0};
        exp_q.push_back(32'h0000_4321);
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'h000F_0000);
        exp_q.push_back(32'h0003_0200);
        acks = 0;
        stall_bad = 0;
        @(negedge i_clk);
        for (int k = 0; k < 5; k++) begin
            if (k > 0 && o_wb_ack === 1'b1) begin
                acks++;
                if (exp_q.size() > 0) check("b2b_rdata", o_wb_data, exp_q.pop_front());
            end
            if (o_wb_stall !== 1'b0) stall_bad++;
            if (k < 4) begin
                drive(v_we[k], v_addr[k], v_dat[k], 4'hF);
                @(negedge i_clk);
            end else begin
                i_wb_stb = 1'b0;
                i_wb_cyc = 1'b0;
                i_wb_we  = 1'b0;
            end
        end
        check("b2b_acks", acks, 32'd4);
        check("b2b_stall", stall_bad, 32'd0);

        // Brightness 3 and digit 1 blanked
        count_an();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bright_dig%0d", i), an_cnt[i], (i == 1) ? 32'd0 : 32'd4);
        end
        check("onehot_an", multi_cnt, 32'd0);

        // Abort: cyc dropped in the ack cycle
        @(negedge i_clk);
        drive(1'b1, 2'd0, 32'hCAFE_F00D, 4'hF);
        @(negedge i_clk);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        #1;
        check("abort_ack", {31'd0, o_wb_ack}, 32'd0);
        xfer(1'b0, 2'd0, 32'd0, 4'hF, rd, ack);
        check("abort_kept", rd, 32'hCAFE_F00D);

        // Reset mid-scan with a strobe in the reset cycle
        @(negedge i_clk);
        i_reset = 1'b1;
        drive(1'b1, 2'd0, 32'hFFFF_FFFF, 4'hF);
        @(negedge i_clk);
        check("mrst_ack", {31'd0, o_wb_ack}, 32'd0);
        check("mrst_an", {24'd0, o_an}, 32'h0000_00FF);
        check("mrst_seg", {25'd0, o_seg}, 32'h0000_007F);
        check("mrst_dp", {31'd0, o_dp}, 32'd1);
        i_reset = 1'b0;
        drive(1'b0, 2'd2, 32'd0, 4'hF);
        @(negedge i_clk);
        check("mrst_st_ack", {31'd0, o_wb_ack}, 32'd1);
        check("mrst_status", o_wb_data, 32'd0);
        i_wb_stb = 1'b0;
        i_wb_cyc = 1'b0;
        xfer(1'b0, 2'd0, 32'd0, 4'hF, rd, ack);
        check("mrst_data", rd, 32'd0);
        xfer(1'b0, 2'd1, 32'd0, 4'hF, rd, ack);
        check("mrst_ctrl", rd, 32'h000F_0000);

        // Leading-zero suppression request
        xfer(1'b1, 2'd0, 32'h0000_00A0, 4'hF, rd, ack);
        xfer(1'b1, 2'd1, 32'h001F_0000, 4'hF, rd, ack);
        xfer(1'b0, 2'd1, 32'd0, 4'hF, rd, ack);
`ifdef SEVENSEG_LZS_EN
        check("lzs_ctrl", rd, 32'h001F_0000);
`else
        check("lzs_ctrl", rd, 32'h000F_0000);
`endif
        count_an();
        for (int i = 0; i < 8; i++) begin
`ifdef SEVENSEG_LZS_EN
            check($sformatf("lzs_dig%0d", i), an_cnt[i], (i < 2) ? 32'd16 : 32'd0);
`else
            check($sformatf("lzs_dig%0d", i), an_cnt[i], 32'd16);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_sevenseg_mux.md
# wb_sevenseg_mux

Parametrised Wishbone (pipelined) slave driving a time-multiplexed common-anode/cathode seven-segment bank of up to 8 digits. It replaces the single-register display peripheral with hex-decoded per-digit data, decimal-point and blank masks, PWM brightness, and a read-only scan status register. It sits on the peripheral bus beside the other `wb_iodevice` blocks, with its outputs routed directly to board pins.

## Interface
- `NUM_DIGITS`, 8: digits driven, 1..8.
- `SLOT_DIV`, 3125: clocks per brightness phase; one digit slot is `16*SLOT_DIV` clocks, ≥1.
- `ACTIVE_LOW`, 1: when 1, `o_seg`, `o_dp` and `o_an` are inverted (asserted = 0).
- Reset is `i_reset`: synchronous, active-high. Clock is `i_clk`.
- `i_clk` in 1: clock.
- `i_reset` in 1: synchronous active-high reset.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we` in 1: bus cycle, strobe, write enable.
- `i_wb_addr` in 30: word address; only `[1:0]` decoded.
- `i_wb_data` in 32: write data.
- `i_wb_sel` in 4: byte enables.
- `o_wb_ack` out 1: acknowledge.
- `o_wb_stall` out 1: tied 0.
- `o_wb_data` out 32: read data.
- `o_seg` out 7: segments a..g, bit 0 = a.
- `o_dp` out 1: decimal point.
- `o_an` out NUM_DIGITS: digit enables; bit i = digit i.

## Operation
- Registers; unimplemented bits read 0 and ignore writes:
  - 0 DATA: nibble i = hex value of digit i.
  - 1 CTRL: `[7:0]` dp mask, `[15:8]` blank mask, `[19:16]` brightness, `[20]` LZS (see Configuration).
  - 2 STATUS (RO): `[2:0]` current digit index, `[7:4]` phase.
  - 3: reads 0; writes ignored.
- Writes honour `i_wb_sel` per byte. Read data is the addressed register's value before any write in the same cycle.
- Reset values: DATA = 0; CTRL = 0x000F_0000; index = 0; phase = 0; prescaler = 0; `o_wb_ack` = 0; `o_wb_data` = 0. Display outputs are inactive: all ones if ACTIVE_LOW.
- Scan machine:
  - The prescaler counts 0..SLOT_DIV-1. On wrap, phase (4 bits) increments.
  - On phase wrap 15→0, the index advances and wraps from NUM_DIGITS-1 to 0.
- Digit i is lit when phase ≤ brightness and blank bit i = 0. Brightness 15 means 100 % on; 0 means 1/16 duty.
- Lit digit drives `o_seg` = hex decode of nibble i and `o_dp` = dp bit i. Unlit slot drives all of `o_an`, `o_seg` and `o_dp` inactive.
- Only one `o_an` bit is ever asserted.

## Timing
- `o_wb_stall` is permanently 0. Every cycle with `cyc&&stb` is accepted, and back-to-back strobes are supported.
- `o_wb_ack` is registered: it is 1 exactly one cycle after each accepted strobe, with `o_wb_data` valid in the same cycle.
- If `i_wb_cyc` is low in the ack cycle, ack is forced to 0 (abort). The write still takes effect.
- A register write becomes visible on display outputs 2 cycles after the strobe: register update, then output register.
- Display outputs are registered and follow index/phase changes by 1 cycle.
- A reset asserted mid-transfer or mid-scan clears everything on the next edge. No ack is issued for a strobe accepted in the reset cycle.

## Configuration
- `SEVENSEG_LZS_EN` defined: CTRL[20] is read/write (reset 0). When it is set, digits above the most significant nonzero nibble are treated as blanked. Digit 0 is never suppressed. This suppression ORs with the blank mask.
- `SEVENSEG_LZS_EN` undefined: CTRL[20] reads 0, writes are ignored, and no suppression logic is built.

## Structure
- `sevenseg_pkg` holds:
  - register address constants: `SS_ADDR_DATA/CTRL/STATUS`;
  - CTRL field bit positions;
  - the CTRL reset constant;
  - the 16-entry hex-to-segment table (a..g, active-high).
- The `sevenseg_hex_decode` sub-module is a combinational 4→7 lookup using the package table and is instantiated once on the selected nibble.
- Scan counters, bus logic and the output register live in the top module.

## Test plan
- Reset, then read CTRL: ack after 1 cycle with data 0x000F_0000. Every `o_an`, `o_seg` and `o_dp` bit = 1 (ACTIVE_LOW = 1).
- Write DATA = 0x8765_4321 with sel = 4'b0011, then read it back → 0x0000_4321. With `SLOT_DIV` = 1, digit 0 shows `1` (o_seg = ~7'b0000110), and `o_an` rotates every 16 cycles.
- Issue 4 back-to-back strobes (write, read, write, read): exactly 4 acks on consecutive cycles, with `o_wb_stall` = 0 throughout.
- Brightness = 3, `SLOT_DIV` = 1: each digit's anode is asserted for 4 of 16 cycles. Blank mask = 0x02 → digit 1 is never asserted.
- Drop `cyc` in the ack cycle → ack = 0 and the write is retained. Assert reset mid-scan → index and phase are 0 and outputs are inactive on the next cycle.
- With `SEVENSEG_LZS_EN` defined, DATA = 0x0000_00A0 and CTRL[20] = 1: only digits 0 and 1 light. With the macro undefined, all 8 digits light and CTRL[20] reads 0.
